// File: rtl/counter_sequencer_if.sv
// Command/status bundle between the board-side controller, the sequencer
// and the counter datapath it drives.
interface counter_sequencer_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             stop;
  logic             clear;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  // Controller / counter side: issues commands, feeds back the count.
  modport master (
    output start, stop, clear, limit, count,
    input  cnt_en, cnt_clr, busy, done, state
  );

  // Sequencer side.
  modport slave (
    input  start, stop, clear, limit, count,
    output cnt_en, cnt_clr, busy, done, state
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run-control sequencer for a free-running up-counter: turns start/stop/clear
// pulses into a clear strobe and a prescaled count enable, and stops the run
// when the fed-back count reaches the latched limit.
module counter_sequencer #(
  parameter int WIDTH = 12,
  parameter int DIV   = 4
) (
  input  logic clk,
  input  logic rst_n,
  counter_sequencer_if.slave ctl_if
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;

  logic             presc_wrap;
  logic [PW-1:0]    presc_step;
  logic [WIDTH-1:0] lim_last;
  logic             terminal;

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign presc_step = presc_wrap ? '0 : presc_q + 1'b1;
  assign lim_last   = lim_q - WIDTH'(1);
  // The enable in flight will carry the counter onto lim_q at this edge.
  assign terminal   = cnt_en_q && (lim_q != '0) && (ctl_if.count == lim_last);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      lim_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lim_q     <= lim_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  // Next state: clear beats everything, terminal beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    if (ctl_if.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ctl_if.start) state_d = (ctl_if.limit == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (terminal)         state_d = S_DONE;
          else if (ctl_if.stop) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (ctl_if.start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: prescaler, limit latch, enable and clear strobes.
  always_comb begin
    presc_d   = presc_q;
    lim_d     = lim_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    if (ctl_if.clear) begin
      presc_d   = '0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ctl_if.start) begin
            lim_d     = ctl_if.limit;
            presc_d   = '0;
            cnt_clr_d = 1'b1;
          end
        end
        S_RUN: begin
          // On the terminal or pausing edge the prescaler freezes, so a
          // resume continues from exactly where the run left off.
          if (!terminal && !ctl_if.stop) begin
            presc_d  = presc_step;
            cnt_en_d = presc_wrap;
          end
        end
        S_PAUSE: begin
          if (ctl_if.start) begin
            presc_d  = presc_step;
            cnt_en_d = presc_wrap;
          end
        end
        default: begin
          presc_d = '0;
        end
      endcase
    end
  end

  // Status decode straight from the state register.
  always_comb begin
    ctl_if.state   = state_q;
    ctl_if.busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
    ctl_if.done    = (state_q == S_DONE);
    ctl_if.cnt_en  = cnt_en_q;
    ctl_if.cnt_clr = cnt_clr_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with a behavioural 12-bit counter.
module tb_counter_sequencer;
  localparam int WIDTH  = 12;
  localparam int DIV    = 4;
  localparam int K_CLR  = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;
  localparam int NO_SHIFT = 1 << 30;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic [WIDTH-1:0] cnt_q = '0;
  logic done_prev = 1'b0;

  counter_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  counter_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl_if(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter datapath model driven by the sequencer strobes.
  always @(posedge clk) begin
    if (ifc.cnt_clr)     cnt_q <= '0;
    else if (ifc.cnt_en) cnt_q <= cnt_q + 1'b1;
  end
  assign ifc.count = cnt_q;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int k, input int c, input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    exp_q.push_back(e);
  endtask

  // Clear strobe at e0, n_en enables every DIV cycles (delayed by shift from
  // enable number shift_k on), then DONE if done_lim >= 0.
  task automatic push_seq(input int e0, input int n_en, input int done_lim,
                          input int shift_k, input int shift);
    push_ev(K_CLR, e0, -1);
    for (int k = 1; k <= n_en; k++)
      push_ev(K_EN, e0 + k * DIV + ((k >= shift_k) ? shift : 0), k - 1);
    if (done_lim == 0)
      push_ev(K_DONE, e0, -1);
    else if (done_lim > 0)
      push_ev(K_DONE, e0 + done_lim * DIV + 1 + ((done_lim >= shift_k) ? shift : 0), done_lim);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected actual kind=%0d cyc=%0d count=%0d expected=none",
               kind, cyc, cnt_q);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (e.cnt >= 0 && e.cnt != int'(cnt_q))) begin
        failures++;
        $display("FAIL sb_event actual kind=%0d cyc=%0d count=%0d expected kind=%0d cyc=%0d count=%0d",
                 kind, cyc, cnt_q, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor: every strobe and every rising done must match the next expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (ifc.cnt_en || ifc.cnt_clr)
        check("en_clr_exclusive", int'(ifc.cnt_en && ifc.cnt_clr), 0);
      if (ifc.cnt_clr) sb_pop(K_CLR);
      if (ifc.cnt_en)  sb_pop(K_EN);
      if (ifc.done && !done_prev) sb_pop(K_DONE);
      done_prev = ifc.done;
    end
  end

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic cmd(input string name, input logic st, input logic sp,
                     input logic cl, input int lim);
    ifc.start = st;
    ifc.stop  = sp;
    ifc.clear = cl;
    ifc.limit = WIDTH'(lim);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    ifc.clear = 1'b0;
    $display("TXN %s start=%0d stop=%0d clear=%0d limit=%0d edge=%0d", name, st, sp, cl, lim, cyc);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    ifc.clear = 1'b0;
    ifc.limit = '0;
    repeat (3) @(negedge clk);
    check("rst_state",   int'(ifc.state), 0);
    check("rst_busy",    int'(ifc.busy), 0);
    check("rst_done",    int'(ifc.done), 0);
    check("rst_cnt_en",  int'(ifc.cnt_en), 0);
    check("rst_cnt_clr", int'(ifc.cnt_clr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // limit=5 from IDLE: enables at +4..+20, done at +21
    e0 = cyc + 1;
    push_seq(e0, 5, 5, NO_SHIFT, 0);
    cmd("start_l5", 1, 0, 0, 5);
    wait_to(e0 + 20);
    check("l5_en_cycle20", int'(ifc.cnt_en), 1);
    check("l5_count_c20", int'(cnt_q), 4);
    wait_to(e0 + 21);
    check("l5_state_done", int'(ifc.state), 3);
    check("l5_done", int'(ifc.done), 1);
    check("l5_busy", int'(ifc.busy), 0);
    check("l5_count", int'(cnt_q), 5);
    wait_to(e0 + 26);
    check("l5_hold", int'(cnt_q), 5);

    // start from DONE with limit=3
    e0 = cyc + 1;
    push_seq(e0, 3, 3, NO_SHIFT, 0);
    cmd("start_done_l3", 1, 0, 0, 3);
    wait_to(e0 + 1);
    check("l3_cleared", int'(cnt_q), 0);
    check("l3_state_run", int'(ifc.state), 1);
    wait_to(e0 + 13);
    check("l3_done", int'(ifc.done), 1);
    check("l3_count", int'(cnt_q), 3);

    // clear from DONE, then limit=0
    e0 = cyc + 1;
    push_ev(K_CLR, e0, -1);
    cmd("clear_done", 0, 0, 1, 0);
    check("clr_state_idle", int'(ifc.state), 0);
    check("clr_done_low", int'(ifc.done), 0);
    e0 = cyc + 1;
    push_seq(e0, 0, 0, NO_SHIFT, 0);
    cmd("start_l0", 1, 0, 0, 0);
    check("l0_state", int'(ifc.state), 3);
    wait_to(e0 + 10);
    check("l0_count", int'(cnt_q), 0);
    check("l0_still_done", int'(ifc.state), 3);

    // limit=100 with a 7-cycle pause after count=3
    e0 = cyc + 1;
    push_seq(e0, 100, 100, 4, 7);
    cmd("start_l100", 1, 0, 0, 100);
    wait_to(e0 + 13);
    check("p_count_before", int'(cnt_q), 3);
    cmd("stop", 0, 1, 0, 0);
    check("p_state", int'(ifc.state), 2);
    check("p_busy", int'(ifc.busy), 1);
    wait_to(e0 + 17);
    check("p_en_low", int'(ifc.cnt_en), 0);
    check("p_frozen", int'(cnt_q), 3);
    cmd("stop_in_pause", 0, 1, 0, 0);
    wait_to(e0 + 20);
    cmd("resume", 1, 0, 0, 55);
    check("p_resumed_state", int'(ifc.state), 1);
    wait_to(e0 + 408);
    check("p_done", int'(ifc.done), 1);
    check("p_count_final", int'(cnt_q), 100);

    // clear during RUN at count=10, then limit=2
    e0 = cyc + 1;
    push_seq(e0, 10, -1, NO_SHIFT, 0);
    cmd("start_l100b", 1, 0, 0, 100);
    wait_to(e0 + 41);
    check("c_count10", int'(cnt_q), 10);
    push_ev(K_CLR, e0 + 42, -1);
    cmd("clear_run", 0, 0, 1, 0);
    wait_to(e0 + 43);
    check("c_count0", int'(cnt_q), 0);
    check("c_state", int'(ifc.state), 0);
    check("c_busy", int'(ifc.busy), 0);
    e0 = cyc + 1;
    push_seq(e0, 2, 2, NO_SHIFT, 0);
    cmd("start_l2", 1, 0, 0, 2);
    wait_to(e0 + 9);
    check("l2_done", int'(ifc.done), 1);
    check("l2_count", int'(cnt_q), 2);

    // start+stop+clear together in RUN -> IDLE
    e0 = cyc + 1;
    push_seq(e0, 2, -1, NO_SHIFT, 0);
    cmd("start_l100c", 1, 0, 0, 100);
    wait_to(e0 + 9);
    push_ev(K_CLR, e0 + 10, -1);
    cmd("all_three", 1, 1, 1, 7);
    check("a3_state", int'(ifc.state), 0);
    check("a3_busy", int'(ifc.busy), 0);

    // start+stop together in RUN -> PAUSE
    e0 = cyc + 1;
    push_seq(e0, 1, -1, NO_SHIFT, 0);
    cmd("start_l100d", 1, 0, 0, 100);
    wait_to(e0 + 5);
    cmd("start_stop", 1, 1, 0, 9);
    check("ss_state", int'(ifc.state), 2);
    wait_to(e0 + 9);
    check("ss_frozen", int'(cnt_q), 1);
    push_ev(K_CLR, e0 + 10, -1);
    cmd("clear_pause", 0, 0, 1, 0);
    check("ss_idle", int'(ifc.state), 0);

    // asynchronous reset during a cnt_en cycle
    e0 = cyc + 1;
    push_seq(e0, 2, -1, NO_SHIFT, 0);
    cmd("start_l100e", 1, 0, 0, 100);
    wait_to(e0 + 8);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", int'(ifc.state), 0);
    check("ar_busy", int'(ifc.busy), 0);
    check("ar_cnt_en", int'(ifc.cnt_en), 0);
    check("ar_done", int'(ifc.done), 0);
    @(negedge clk);
    check("ar_held", int'(ifc.state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // full-range limit, no wrap
    e0 = cyc + 1;
    push_seq(e0, 4095, 4095, NO_SHIFT, 0);
    cmd("start_l4095", 1, 0, 0, 4095);
    wait_to(e0 + 16380);
    check("max_state_run", int'(ifc.state), 1);
    check("max_count4094", int'(cnt_q), 4094);
    wait_to(e0 + 16381);
    check("max_done", int'(ifc.done), 1);
    check("max_count", int'(cnt_q), 4095);
    wait_to(e0 + 16386);
    check("max_no_wrap", int'(cnt_q), 4095);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run-control sequencer for the lab's 12-bit free-running up-counter datapath. It converts single-cycle start/stop/clear commands into a clear strobe and a prescaled count-enable for the counter, and latches a terminal limit. It watches the counter's value and stops the count when that value reaches the limit. It sits between the board's command pulses and the counter, and exports run status for LEDs or a display.

## Interface
- WIDTH, 12, width of count and limit
- DIV, 4, prescale ratio: one cnt_en pulse per DIV clocks while running; legal range 2..65535

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command: begin (IDLE/DONE) or resume (PAUSE)
- stop  in  1  single-cycle command: pause while RUN
- clear  in  1  single-cycle command: abort to IDLE and zero the counter
- limit  in  WIDTH  terminal value, sampled only when start is accepted from IDLE/DONE
- count  in  WIDTH  current counter value, fed back from the counter
- cnt_en  out  1  registered; counter increments on an edge where it is high
- cnt_clr  out  1  registered; counter synchronously zeroes on an edge where it is high
- busy  out  1  registered; high in RUN or PAUSE
- done  out  1  registered; high in DONE
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE, prescaler=0, lim_q=0. cnt_en, cnt_clr, busy and done are all 0.
- Command priority on the same edge: clear > stop > start.
- clear, any state -> IDLE:
  - cnt_clr=1 for one cycle.
  - Prescaler zeroed; cnt_en forced 0.
- IDLE or DONE, start:
  - lim_q <= limit; cnt_clr=1 for one cycle; prescaler <= 0.
  - If limit==0: -> DONE, and cnt_en is never issued.
  - Otherwise: -> RUN.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - cnt_en is high for one cycle each time the prescaler wraps.
  - On the edge where cnt_en is high and count==lim_q-1: -> DONE. The counter reaches lim_q on that same edge.
  - stop -> PAUSE.
  - start is ignored.
- PAUSE:
  - Prescaler holds its value; cnt_en=0.
  - start -> RUN; the prescaler resumes from the held value, and limit is not resampled.
  - stop is ignored.
- DONE:
  - cnt_en=0 and the counter holds at lim_q.
  - stop is ignored.
- cnt_en and cnt_clr are never high in the same cycle.
- Commands that are ignored leave no side effects.
- lim_q is a full WIDTH value; the maximum limit (2^WIDTH-1) is reachable without counter wrap.
- The comparison lim_q-1 is computed in WIDTH bits. It is only evaluated when lim_q≠0.

## Timing
- Start accepted at edge E0:
  - cnt_clr is high during cycle E0->E1.
  - The first cnt_en is high during cycle E0+DIV -> E0+DIV+1.
  - Later cnt_en pulses follow every DIV cycles.
  - The count therefore reaches 1 at edge E0+DIV+1.
- Limit L from a fresh start:
  - The counter reaches L at edge E0+L·DIV+1.
  - state=DONE and done=1 from that same edge.
- Pause and resume: pause at edge P, resume at edge R.
  - The next cnt_en is delayed by exactly R-P cycles relative to an uninterrupted run.
- Stop and start in the same cycle while RUN: stop wins -> PAUSE.
- clear on the same edge as a terminal cnt_en: -> IDLE with cnt_clr=1 and done=0.
- Status outputs (busy, done, state) change on the same edge as the state transition.
- Reset asserted mid-RUN: all outputs drop to 0 immediately, without waiting for a clock edge. The first accepted command after rst_n deasserts must be start.

## Test plan
- Reset, then start with limit=5, DIV=4 at edge 0 -> cnt_clr high in cycle 0, cnt_en high in cycles 4, 8, 12, 16, 20; count=5 and done=1 at edge 21; busy=0.
- Start with limit=0 -> next cycle state=DONE and done=1; cnt_clr pulses once; cnt_en never asserts.
- Run with limit=100; stop after count=3; hold 7 cycles; start -> PAUSE shows busy=1, cnt_en=0, and count frozen at 3; the next cnt_en arrives 7 cycles later than in an unpaused run; done when count=100.
- clear during RUN at count=10 -> state=IDLE, cnt_clr for one cycle, count=0, busy=0; a later start with limit=2 runs normally.
- Simultaneous start+stop+clear in RUN -> clear wins, IDLE. Simultaneous start+stop in RUN -> PAUSE. start in DONE with limit=3 -> counter cleared, reruns, done at count=3.
- Assert rst_n=0 asynchronously mid-RUN, off a clock edge -> state=00 and all outputs 0 before the next clk edge; limit=4095 run completes with done at count=4095 and no wrap.
